// File: rtl/ppu_dma_pkg.sv
// rtl/ppu_dma_pkg.sv - shared types for the PPU DMA engine
package ppu_dma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN1 = 3'd1,
    ALIGN2 = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4
  } dma_state_t;

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - byte counter, last-byte compare and destination stride accumulator
module dma_addr_gen #(
  parameter int DST_AW = 11,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              clr,
  input  logic              inc,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DST_AW-1:0] stride,
  output logic [LEN_W-1:0]  cnt,
  output logic [DST_AW-1:0] acc,
  output logic              last
);

  // Counter and accumulator only move on steps; clear wins over increment.
  // Both wrap silently, so stride*count overflow aliases onto low addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (step) begin
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (inc) begin
        cnt <= cnt + LEN_W'(1);
        acc <= acc + stride;
      end
    end
  end

  assign last = (cnt == cfg_len);

endmodule

// File: rtl/ppu_dma_engine.sv
// rtl/ppu_dma_engine.sv - parametrised copy/fill DMA from CPU space into PPU-side memory
module ppu_dma_engine
  import ppu_dma_pkg::*;
#(
  parameter int SRC_AW = 16,
  parameter int DST_AW = 11,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_clk_en,
  input  logic              cpu_cyc_par,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_fill,
  input  logic [SRC_AW-1:0] cfg_src_addr,
  input  logic [DST_AW-1:0] cfg_dst_addr,
  input  logic [DST_AW-1:0] cfg_dst_stride,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [7:0]        cfg_fill_val,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_re,
  input  logic [7:0]        src_rd_data,
  output logic [DST_AW-1:0] dst_addr,
  output logic              dst_we,
  output logic [7:0]        dst_data,
  output logic              cpu_sus,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  dma_state_t        state;
  dma_state_t        state_nx;

  logic              fill_q;
  logic [SRC_AW-1:0] src_base_q;
  logic [DST_AW-1:0] dst_base_q;
  logic [DST_AW-1:0] stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        fill_val_q;

  logic              ag_clr;
  logic              ag_inc;
  logic [LEN_W-1:0]  cnt;
  logic [DST_AW-1:0] acc;
  logic              last;

  logic              accept;

  assign accept = cpu_clk_en && start && (state == IDLE);

  // State register; the machine only advances on CPU steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (cpu_clk_en) begin
      state <= state_nx;
    end
  end

  // Configuration snapshot taken on the accepted start step, so the
  // register interface may change cfg_* freely while a transfer runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= 1'b0;
      src_base_q <= '0;
      dst_base_q <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      fill_val_q <= 8'h00;
    end else if (accept) begin
      fill_q     <= cfg_fill;
      src_base_q <= cfg_src_addr;
      dst_base_q <= cfg_dst_addr;
      stride_q   <= cfg_dst_stride;
      len_q      <= cfg_len;
      fill_val_q <= cfg_fill_val;
    end
  end

  dma_addr_gen #(
    .DST_AW (DST_AW),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .step    (cpu_clk_en),
    .clr     (ag_clr),
    .inc     (ag_inc),
    .cfg_len (len_q),
    .stride  (stride_q),
    .cnt     (cnt),
    .acc     (acc),
    .last    (last)
  );

  // Next-state and strobes; abort overrides everything, including the final write.
  always_comb begin
    state_nx = state;
    cpu_sus  = 1'b0;
    src_re   = 1'b0;
    dst_we   = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
    ag_clr   = 1'b0;
    ag_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cpu_sus  = 1'b1;
          state_nx = ALIGN1;
        end
      end
      ALIGN1: begin
        cpu_sus = 1'b1;
        ag_clr  = 1'b1;
        if (cpu_cyc_par) begin
          state_nx = ALIGN2;
        end else begin
          state_nx = fill_q ? WRITE : READ;
        end
      end
      ALIGN2: begin
        cpu_sus  = 1'b1;
        state_nx = fill_q ? WRITE : READ;
      end
      READ: begin
        cpu_sus  = 1'b1;
        src_re   = cpu_clk_en;
        state_nx = WRITE;
      end
      WRITE: begin
        dst_we = cpu_clk_en;
        if (last) begin
          done     = cpu_clk_en;
          state_nx = IDLE;
        end else begin
          cpu_sus  = 1'b1;
          ag_inc   = 1'b1;
          state_nx = fill_q ? WRITE : READ;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if ((state != IDLE) && abort) begin
      src_re   = 1'b0;
      dst_we   = 1'b0;
      done     = 1'b0;
      ag_inc   = 1'b0;
      aborted  = cpu_clk_en;
      state_nx = IDLE;
    end
  end

  assign busy     = (state != IDLE);
  assign src_addr = src_base_q + SRC_AW'(cnt);
  assign dst_addr = dst_base_q + acc;
  assign dst_data = (state == WRITE) ? (fill_q ? fill_val_q : src_rd_data) : 8'h00;

endmodule

// File: tb/tb_ppu_dma_engine.sv
// tb/tb_ppu_dma_engine.sv - scoreboard bench for ppu_dma_engine
module tb_ppu_dma_engine;

  logic        clk;
  logic        rst;
  logic        cpu_clk_en;
  logic        cpu_cyc_par;
  logic        start;
  logic        abort;
  logic        cfg_fill;
  logic [15:0] cfg_src_addr;
  logic [10:0] cfg_dst_addr;
  logic [10:0] cfg_dst_stride;
  logic [7:0]  cfg_len;
  logic [7:0]  cfg_fill_val;
  logic [15:0] src_addr;
  logic        src_re;
  logic [7:0]  src_rd_data;
  logic [10:0] dst_addr;
  logic        dst_we;
  logic [7:0]  dst_data;
  logic        cpu_sus;
  logic        busy;
  logic        done;
  logic        aborted;

  ppu_dma_engine #(
    .SRC_AW (16),
    .DST_AW (11),
    .LEN_W  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_clk_en     (cpu_clk_en),
    .cpu_cyc_par    (cpu_cyc_par),
    .start          (start),
    .abort          (abort),
    .cfg_fill       (cfg_fill),
    .cfg_src_addr   (cfg_src_addr),
    .cfg_dst_addr   (cfg_dst_addr),
    .cfg_dst_stride (cfg_dst_stride),
    .cfg_len        (cfg_len),
    .cfg_fill_val   (cfg_fill_val),
    .src_addr       (src_addr),
    .src_re         (src_re),
    .src_rd_data    (src_rd_data),
    .dst_addr       (dst_addr),
    .dst_we         (dst_we),
    .dst_data       (dst_data),
    .cpu_sus        (cpu_sus),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int sus_cnt   = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  int cyc       = 0;
  bit en_gap    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Synchronous source memory: data appears the step after the read strobe.
  always @(posedge clk) begin
    if (src_re) src_rd_data <= src_byte(src_addr);
  end

  // Step enable: every cycle, or two out of three when gaps are requested.
  initial begin
    cpu_clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      cpu_clk_en = en_gap ? ((cyc % 3) != 0) : 1'b1;
    end
  end

  // Monitor: pop and compare each destination write, count suspend steps and pulses.
  always @(negedge clk) begin
    if (dst_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {dst_addr, dst_data}, 64'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr_data", {dst_addr, dst_data}, {e.a, e.d});
      end
    end
    if (cpu_clk_en && cpu_sus) sus_cnt++;
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  task automatic setup(input logic fill, input logic [15:0] s, input logic [10:0] d,
                       input logic [10:0] st, input logic [7:0] len, input logic [7:0] fv,
                       input logic par);
    @(posedge clk);
    #1;
    cfg_fill = fill; cfg_src_addr = s; cfg_dst_addr = d;
    cfg_dst_stride = st; cfg_len = len; cfg_fill_val = fv; cpu_cyc_par = par;
    sus_cnt = 0; done_cnt = 0; abort_cnt = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wr_t e;
      logic [15:0] sa;
      sa = s + 16'(i);
      e.a = d + 11'(i * int'(st));
      e.d = fill ? fv : src_byte(sa);
      exp_q.push_back(e);
    end
  endtask

  task automatic launch();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!cpu_clk_en && n < 20);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int base;
    int n;
    base = done_cnt + abort_cnt;
    n = 0;
    while ((done_cnt + abort_cnt) == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("end_seen", ((done_cnt + abort_cnt) > base), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cpu_cyc_par = 1'b0;
    cfg_fill = 1'b0; cfg_src_addr = '0; cfg_dst_addr = '0;
    cfg_dst_stride = '0; cfg_len = '0; cfg_fill_val = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {src_addr, src_re, dst_addr, dst_we, dst_data, cpu_sus, busy, done, aborted}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // copy 256 bytes, parity 0
    setup(1'b0, 16'h0200, 11'h000, 11'd1, 8'hFF, 8'h00, 1'b0);
    launch();
    wait_end(2000);
    chk("copy_p0_sus", sus_cnt, 513);
    chk("copy_p0_done", done_cnt, 1);
    chk("copy_p0_drained", exp_q.size(), 0);

    // same copy, parity 1, with step gaps; back-to-back style restart
    en_gap = 1;
    setup(1'b0, 16'h0200, 11'h000, 11'd1, 8'hFF, 8'h00, 1'b1);
    launch();
    wait_end(3000);
    chk("copy_p1_sus", sus_cnt, 514);
    chk("copy_p1_done", done_cnt, 1);
    chk("copy_p1_drained", exp_q.size(), 0);
    en_gap = 0;

    // fill 30 bytes of 0x24 at stride 32
    setup(1'b1, 16'h0000, 11'h000, 11'd32, 8'd29, 8'h24, 1'b0);
    launch();
    wait_end(200);
    chk("fill_sus", sus_cnt, 31);
    chk("fill_done", done_cnt, 1);
    chk("fill_drained", exp_q.size(), 0);

    // abort on second write; start while busy must be ignored
    setup(1'b0, 16'h1000, 11'h100, 11'd2, 8'd3, 8'h00, 1'b0);
    exp_q.delete();
    begin
      wr_t e;
      e.a = 11'h100;
      e.d = src_byte(16'h1000);
      exp_q.push_back(e);
    end
    launch();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dst_we && n < 20);
    chk("abort_first_write_seen", dst_we, 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_dst_addr = 11'h555;
    @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("abort_pulse", aborted, 1);
    chk("abort_no_we", dst_we, 0);
    chk("abort_no_done", done, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_next", busy, 0);
    repeat (10) @(negedge clk);
    chk("abort_cnt", abort_cnt, 1);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_drained", exp_q.size(), 0);

    // destination and source wrap
    setup(1'b0, 16'hFFFE, 11'h7FE, 11'd1, 8'd3, 8'h00, 1'b0);
    launch();
    wait_end(100);
    chk("wrap_sus", sus_cnt, 9);
    chk("wrap_done", done_cnt, 1);
    chk("wrap_drained", exp_q.size(), 0);

    // reset mid-copy, then a fresh transfer
    setup(1'b0, 16'h0200, 11'h000, 11'd1, 8'hFF, 8'h00, 1'b0);
    launch();
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {src_addr, src_re, dst_addr, dst_we, dst_data, cpu_sus, busy, done, aborted}, 64'h0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    en_gap = 1;
    setup(1'b0, 16'h0300, 11'h040, 11'd3, 8'd7, 8'h00, 1'b1);
    launch();
    wait_end(200);
    chk("fresh_sus", sus_cnt, 18);
    chk("fresh_done", done_cnt, 1);
    chk("fresh_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
